queue_access_ctrl: RTL and testbench

//  Sequencer and arbiter in front of the 6-bit special queue. Shares the queue's push side

---
 rtl/queue_ctrl_pkg.sv | 17 +
 rtl/rr_pick.sv | 44 ++++
 rtl/queue_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_queue_access_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_ctrl_pkg.sv
// Shared types and constants for the special-queue access controller.
//  state_e : controller FSM states (idle, push issue, pop issue, settle)
//  DATA_W  : queue entry width
//  SEL_W   : queue read-select width
package queue_ctrl_pkg;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPush,
    StPop,
    StSettle
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req upward from rr_ptr, wrapping modulo NUM_REQ, and reports the
// first asserted requester.
//  req       in   NUM_REQ  request vector
//  rr_ptr    in   PTR_W    index to start the search from
//  winner    out  NUM_REQ  one-hot winner (zero when nothing requested)
//  win_idx   out  PTR_W    winner index
//  win_valid out  1        at least one request asserted
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    winner    = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // rr_ptr < NUM_REQ, so one conditional subtract implements the wrap.
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!win_valid && req[cand]) begin
        win_valid    = 1'b1;
        win_idx      = cand;
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_access_ctrl.sv
// Sequencer/arbiter in front of the special queue. Round-robin shares the
// push side among NUM_REQ producers and serves one consumer's pops. Every
// operation is followed by a settle cycle so the queue flags are valid at the
// next idle decision. All outputs are registered.
//  clk        in   clock, rising edge
//  rst_n      in   synchronous reset, active HIGH (legacy name)
//  req        in   per-producer push request, held until granted
//  req_data   in   producer i data at [i*DATA_W +: DATA_W]
//  gnt        out  one-hot pulse: producer pushed this cycle
//  rd_req     in   consumer pop request, held until rd_ack
//  rd_sel_in  in   consumer read select, captured at the pop decision
//  rd_ack     out  pulse: pop issued this cycle
//  q_push     out  queue push
//  q_pop      out  queue pop
//  q_data_in  out  queue write data
//  q_rd_sel   out  queue read select, holds between pops
//  q_full     in   queue full flag
//  q_empty    in   queue empty flag
//  busy       out  controller in push/pop/settle
module queue_access_ctrl #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = queue_ctrl_pkg::DATA_W,
  parameter int unsigned SEL_W   = queue_ctrl_pkg::SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      rd_req,
  input  logic [SEL_W-1:0]          rd_sel_in,
  output logic                      rd_ack,
  output logic                      q_push,
  output logic                      q_pop,
  output logic [DATA_W-1:0]         q_data_in,
  output logic [SEL_W-1:0]          q_rd_sel,
  input  logic                      q_full,
  input  logic                      q_empty,
  output logic                      busy
);

  import queue_ctrl_pkg::*;

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 prefer_pop_q, prefer_pop_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 rd_ack_q, rd_ack_d;
  logic                 q_push_q, q_push_d;
  logic                 q_pop_q, q_pop_d;
  logic [DATA_W-1:0]    q_data_in_q, q_data_in_d;
  logic [SEL_W-1:0]     q_rd_sel_q, q_rd_sel_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   win_onehot;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_valid;
  logic                 push_ok, pop_ok;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .winner    (win_onehot),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign push_ok = win_valid && !q_full;
  assign pop_ok  = rd_req && !q_empty;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    prefer_pop_d = prefer_pop_q;
    gnt_d        = '0;
    rd_ack_d     = 1'b0;
    q_push_d     = 1'b0;
    q_pop_d      = 1'b0;
    q_data_in_d  = q_data_in_q;
    q_rd_sel_d   = q_rd_sel_q;
    unique case (state_q)
      StIdle: begin
        // On contention prefer_pop alternates service between the two sides.
        if (push_ok && !(pop_ok && prefer_pop_q)) begin
          state_d      = StPush;
          q_push_d     = 1'b1;
          gnt_d        = win_onehot;
          q_data_in_d  = req_data[win_idx*DATA_W +: DATA_W];
          rr_ptr_d     = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
          prefer_pop_d = 1'b1;
        end else if (pop_ok) begin
          state_d      = StPop;
          q_pop_d      = 1'b1;
          rd_ack_d     = 1'b1;
          q_rd_sel_d   = rd_sel_in;
          prefer_pop_d = 1'b0;
        end
      end
      StPush:   state_d = StSettle;
      StPop:    state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      prefer_pop_q <= 1'b1;
      gnt_q        <= '0;
      rd_ack_q     <= 1'b0;
      q_push_q     <= 1'b0;
      q_pop_q      <= 1'b0;
      q_data_in_q  <= '0;
      q_rd_sel_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      prefer_pop_q <= prefer_pop_d;
      gnt_q        <= gnt_d;
      rd_ack_q     <= rd_ack_d;
      q_push_q     <= q_push_d;
      q_pop_q      <= q_pop_d;
      q_data_in_q  <= q_data_in_d;
      q_rd_sel_q   <= q_rd_sel_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rd_ack    = rd_ack_q;
  assign q_push    = q_push_q;
  assign q_pop     = q_pop_q;
  assign q_data_in = q_data_in_q;
  assign q_rd_sel  = q_rd_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_queue_access_ctrl.sv
// Self-checking bench for queue_access_ctrl: expected operations are queued
// when stimulus is applied and compared when the DUT issues a push or pop.
module tb_queue_access_ctrl;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 6;
  localparam int unsigned SW = 4;
  localparam logic [DW-1:0] D0 = 6'h0A;
  localparam logic [DW-1:0] D1 = 6'h15;
  localparam logic [DW-1:0] D2 = 6'h2C;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic              rd_req;
  logic [SW-1:0]     rd_sel_in;
  logic              rd_ack;
  logic              q_push;
  logic              q_pop;
  logic [DW-1:0]     q_data_in;
  logic [SW-1:0]     q_rd_sel;
  logic              q_full;
  logic              q_empty;
  logic              busy;

  typedef struct {
    bit            push;
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } op_t;

  op_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  int  cyc = 0;
  int  last_op = -10;
  int  overlap_cnt = 0;
  int  spacing_bad = 0;

  queue_access_ctrl #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .SEL_W   (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .rd_req    (rd_req),
    .rd_sel_in (rd_sel_in),
    .rd_ack    (rd_ack),
    .q_push    (q_push),
    .q_pop     (q_pop),
    .q_data_in (q_data_in),
    .q_rd_sel  (q_rd_sel),
    .q_full    (q_full),
    .q_empty   (q_empty),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Background monitor: push/pop exclusivity and minimum 3-cycle op spacing.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      last_op = -10;
    end else begin
      if (q_push && q_pop) overlap_cnt++;
      if (q_push || q_pop) begin
        if (cyc - last_op < 3) spacing_bad++;
        last_op = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the DUT issues an operation (bounded), then pop the expectation.
  task automatic take_op(input int budget, output bit got, output int ticks, output op_t e);
    got   = 1'b0;
    ticks = 0;
    while (!got && ticks < budget) begin
      tick();
      ticks++;
      got = q_push || q_pop;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{push: 1'b0, gnt: '0, data: '0, sel: '0};
  endtask

  task automatic test_reset();
    bit got; int t; op_t e;
    rst_n = 1'b1; req = 3'b111; rd_req = 1'b0; rd_sel_in = '0;
    q_full = 1'b0; q_empty = 1'b1; req_data = {D2, D1, D0};
    tick(); tick();
    total++;
    if ({gnt, rd_ack, q_push, q_pop, busy, q_data_in, q_rd_sel} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b ack=%b push=%b pop=%b busy=%b data=%h sel=%h, required all 0",
               gnt, rd_ack, q_push, q_pop, busy, q_data_in, q_rd_sel);
    end
    rst_n = 1'b0;
    exp_q.push_back('{push: 1'b1, gnt: 3'b001, data: D0, sel: '0});
    take_op(4, got, t, e);
    total++;
    if (!got || !q_push || q_pop || gnt !== e.gnt || q_data_in !== e.data || rd_ack) begin
      bad++;
      $display("FAIL reset_first_grant: got=%0b push=%b pop=%b gnt=%b data=%h, required gnt=%b data=%h",
               got, q_push, q_pop, gnt, q_data_in, e.gnt, e.data);
    end
    total++;
    if (t != 1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_latency: ticks=%0d busy=%b, required ticks=1 busy=1", t, busy);
    end
  endtask

  task automatic test_round_robin();
    bit got; int t; op_t e;
    logic [DW-1:0] dv [NR];
    dv[0] = D0; dv[1] = D1; dv[2] = D2;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (i + 1) % 3;
      exp_q.push_back('{push: 1'b1, gnt: 3'b001 << k, data: dv[k], sel: '0});
      take_op(6, got, t, e);
      total++;
      if (!got || !q_push || q_pop || gnt !== e.gnt || q_data_in !== e.data || rd_ack) begin
        bad++;
        $display("FAIL rr_grant%0d: got=%0b push=%b pop=%b gnt=%b data=%h, required gnt=%b data=%h",
                 i, got, q_push, q_pop, gnt, q_data_in, e.gnt, e.data);
      end
      total++;
      if (t != 3) begin
        bad++;
        $display("FAIL rr_spacing%0d: ticks=%0d, required 3", i, t);
      end
    end
  endtask

  task automatic test_withdraw();
    bit got; int t; op_t e;
    // rr_ptr is 1 here; requester 1 drops before the idle decision.
    req = 3'b011;
    tick(); tick();
    req = 3'b001;
    exp_q.push_back('{push: 1'b1, gnt: 3'b001, data: D0, sel: '0});
    take_op(4, got, t, e);
    total++;
    if (!got || !q_push || gnt !== e.gnt || q_data_in !== e.data || t != 1) begin
      bad++;
      $display("FAIL withdraw: got=%0b push=%b gnt=%b data=%h ticks=%0d, required gnt=%b data=%h ticks=1",
               got, q_push, gnt, q_data_in, t, e.gnt, e.data);
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_alternation();
    bit got; int t; op_t e;
    req = 3'b010; rd_req = 1'b1; rd_sel_in = 4'd5; q_empty = 1'b0; q_full = 1'b0;
    exp_q.push_back('{push: 1'b0, gnt: '0, data: '0, sel: 4'd5});
    exp_q.push_back('{push: 1'b1, gnt: 3'b010, data: D1, sel: '0});
    exp_q.push_back('{push: 1'b0, gnt: '0, data: '0, sel: 4'd9});
    take_op(4, got, t, e);
    total++;
    if (!got || q_push || !q_pop || !rd_ack || gnt !== '0 || q_rd_sel !== e.sel || t != 1) begin
      bad++;
      $display("FAIL alt_pop1: got=%0b push=%b pop=%b ack=%b sel=%h ticks=%0d, required pop sel=%h ticks=1",
               got, q_push, q_pop, rd_ack, q_rd_sel, t, e.sel);
    end
    rd_sel_in = 4'd9;
    take_op(6, got, t, e);
    total++;
    if (!got || !q_push || q_pop || rd_ack || gnt !== e.gnt || q_data_in !== e.data || t != 3) begin
      bad++;
      $display("FAIL alt_push: got=%0b push=%b pop=%b gnt=%b data=%h ticks=%0d, required gnt=%b data=%h ticks=3",
               got, q_push, q_pop, gnt, q_data_in, t, e.gnt, e.data);
    end
    total++;
    if (q_rd_sel !== 4'd5) begin
      bad++;
      $display("FAIL alt_sel_hold: q_rd_sel=%h, required 5", q_rd_sel);
    end
    req = '0;
    take_op(6, got, t, e);
    total++;
    if (!got || q_push || !q_pop || !rd_ack || q_rd_sel !== e.sel || t != 3) begin
      bad++;
      $display("FAIL alt_pop2: got=%0b push=%b pop=%b ack=%b sel=%h ticks=%0d, required pop sel=%h ticks=3",
               got, q_push, q_pop, rd_ack, q_rd_sel, t, e.sel);
    end
    rd_req = 1'b0;
    tick(); tick(); tick();
    total++;
    if (q_rd_sel !== 4'd9 || q_pop || q_push || busy) begin
      bad++;
      $display("FAIL alt_quiet: sel=%h pop=%b push=%b busy=%b, required sel=9 pop=0 push=0 busy=0",
               q_rd_sel, q_pop, q_push, busy);
    end
  endtask

  task automatic test_full_empty();
    bit got; int t; op_t e; int seen;
    req = 3'b100; q_full = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (q_push || gnt !== '0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL full_blocks: push cycles=%0d, required 0", seen);
    end
    q_full = 1'b0;
    exp_q.push_back('{push: 1'b1, gnt: 3'b100, data: D2, sel: '0});
    take_op(4, got, t, e);
    total++;
    if (!got || !q_push || gnt !== e.gnt || q_data_in !== e.data || t > 2) begin
      bad++;
      $display("FAIL full_release: got=%0b push=%b gnt=%b data=%h ticks=%0d, required gnt=%b data=%h ticks<=2",
               got, q_push, gnt, q_data_in, t, e.gnt, e.data);
    end
    req = '0;
    tick(); tick(); tick();
    rd_req = 1'b1; rd_sel_in = 4'd3; q_empty = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (q_pop || rd_ack) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL empty_blocks: pop cycles=%0d, required 0", seen);
    end
    q_empty = 1'b0;
    exp_q.push_back('{push: 1'b0, gnt: '0, data: '0, sel: 4'd3});
    take_op(4, got, t, e);
    total++;
    if (!got || !q_pop || !rd_ack || q_push || q_rd_sel !== e.sel || t > 2) begin
      bad++;
      $display("FAIL empty_release: got=%0b pop=%b ack=%b sel=%h ticks=%0d, required sel=%h ticks<=2",
               got, q_pop, rd_ack, q_rd_sel, t, e.sel);
    end
    rd_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_midop();
    bit got; int t; op_t e;
    req = 3'b111;
    exp_q.push_back('{push: 1'b1, gnt: 3'b001, data: D0, sel: '0});
    take_op(4, got, t, e);
    total++;
    if (!got || !q_push || gnt !== e.gnt || q_data_in !== e.data) begin
      bad++;
      $display("FAIL midop_push: got=%0b push=%b gnt=%b data=%h, required gnt=%b data=%h",
               got, q_push, gnt, q_data_in, e.gnt, e.data);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({gnt, rd_ack, q_push, q_pop, busy, q_data_in, q_rd_sel} !== '0) begin
      bad++;
      $display("FAIL midop_reset: gnt=%b ack=%b push=%b pop=%b busy=%b data=%h sel=%h, required all 0",
               gnt, rd_ack, q_push, q_pop, busy, q_data_in, q_rd_sel);
    end
    rst_n = 1'b0;
    // rr_ptr back at 0: requester 0 wins again rather than requester 1.
    exp_q.push_back('{push: 1'b1, gnt: 3'b001, data: D0, sel: '0});
    take_op(4, got, t, e);
    total++;
    if (!got || !q_push || gnt !== e.gnt || q_data_in !== e.data || t != 1) begin
      bad++;
      $display("FAIL midop_rrptr: got=%0b push=%b gnt=%b data=%h ticks=%0d, required gnt=%b data=%h ticks=1",
               got, q_push, gnt, q_data_in, t, e.gnt, e.data);
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_exclusive();
    total++;
    if (overlap_cnt != 0 || spacing_bad != 0) begin
      bad++;
      $display("FAIL push_pop_exclusive: overlaps=%0d spacing_violations=%0d, required 0 and 0",
               overlap_cnt, spacing_bad);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: leftover=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_withdraw();
    test_alternation();
    test_full_empty();
    test_reset_midop();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
